// File: rtl/play_pkg.sv
// Shared types and default parameter values for the clip playback engine.
package play_pkg;

   localparam int unsigned DEF_ADDR_W   = 23;
   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_CHANNELS = 2;

   typedef enum logic [2:0] {
      StIdle,
      StReadLen,
      StRead,
      StPlay,
      StPause
   } state_e;

   typedef enum logic [1:0] {
      MODE_NORMAL,
      MODE_FAST,
      MODE_SLOW,
      MODE_REVERSE
   } mode_e;

endpackage

// File: rtl/play_engine_if.sv
// SDRAM read port and audio sink handshake of the playback engine.
interface play_engine_if import play_pkg::*; #(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);
   logic              play_read;
   logic [ADDR_W-1:0] play_addr;
   logic [DATA_W-1:0] play_readdata;
   logic              play_sdram_finished;
   logic              play_audio_valid;
   logic [DATA_W-1:0] play_audio_data;
   logic              play_audio_ready;

   modport master (
      output play_read, play_addr, play_audio_valid, play_audio_data,
      input  play_readdata, play_sdram_finished, play_audio_ready
   );

   modport slave (
      input  play_read, play_addr, play_audio_valid, play_audio_data,
      output play_readdata, play_sdram_finished, play_audio_ready
   );
endinterface

// File: rtl/play_engine.sv
// Clip playback engine: reads a length header, then streams sample words from SDRAM to an
// audio sink with speed/reverse/loop modes, pause and stop.
module play_engine import play_pkg::*; #(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned CHANNELS = DEF_CHANNELS
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              play_start,
   input  logic [ADDR_W-1:0] play_select,
   input  logic [1:0]        play_mode,
   input  logic              play_loop,
   input  logic              play_pause,
   input  logic              play_stop,
   output logic              play_done,
   output logic [ADDR_W-1:0] play_pos,
   play_engine_if.master     bus
);

   localparam int unsigned CNT_W = $clog2(2 * CHANNELS + 1);

   state_e              state_q, state_d;
   mode_e               mode_q, mode_d;
   logic                loop_q, loop_d;
   logic                stop_q, stop_d;
   logic                done_q, done_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   first_q, first_d;
   logic [ADDR_W-1:0]   len_q, len_d;
   logic [ADDR_W-1:0]   pos_q, pos_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;

   logic                valid;
   logic                hs;
   logic                stop_any;
   logic [CNT_W-1:0]    per_word;
   logic [ADDR_W-1:0]   rd_len;
   logic [ADDR_W-1:0]   pos_n;
   logic [ADDR_W-1:0]   addr_n;

   // Pause gates valid combinationally so no handshake can slip through the pausing cycle.
   assign valid                = ((state_q == StPlay) || (state_q == StPause)) && !play_pause;
   assign bus.play_read        = (state_q == StReadLen) || (state_q == StRead);
   assign bus.play_addr        = addr_q;
   assign bus.play_audio_valid = valid;
   assign bus.play_audio_data  = data_q;
   assign play_done            = done_q;
   assign play_pos             = pos_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         mode_q  <= MODE_NORMAL;
         loop_q  <= 1'b0;
         stop_q  <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
         first_q <= '0;
         len_q   <= '0;
         pos_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         loop_q  <= loop_d;
         stop_q  <= stop_d;
         done_q  <= done_d;
         addr_q  <= addr_d;
         first_q <= first_d;
         len_q   <= len_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      loop_d   = loop_q;
      stop_d   = stop_q;
      done_d   = 1'b0;
      addr_d   = addr_q;
      first_d  = first_q;
      len_d    = len_q;
      pos_d    = pos_q;
      cnt_d    = cnt_q;
      data_d   = data_q;

      hs       = valid && bus.play_audio_ready;
      stop_any = stop_q || play_stop;
      rd_len   = bus.play_readdata[ADDR_W-1:0];
      per_word = (mode_q == MODE_SLOW) ? CNT_W'(2 * CHANNELS) : CNT_W'(CHANNELS);
      pos_n    = pos_q + ((mode_q == MODE_FAST) ? ADDR_W'(2) : ADDR_W'(1));
      addr_n   = (mode_q == MODE_REVERSE) ? addr_q - ADDR_W'(1) :
                 addr_q + ((mode_q == MODE_FAST) ? ADDR_W'(2) : ADDR_W'(1));

      unique case (state_q)
         StIdle: begin
            if (play_start) begin
               state_d = StReadLen;
               addr_d  = play_select;
               mode_d  = mode_e'(play_mode);
               loop_d  = play_loop;
               stop_d  = 1'b0;
               pos_d   = '0;
               cnt_d   = '0;
            end
         end
         StReadLen: begin
            // A stop here is held until the header read retires.
            stop_d = stop_any;
            if (bus.play_sdram_finished) begin
               stop_d = 1'b0;
               len_d  = rd_len;
               if (stop_any || (rd_len == '0)) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  first_d = (mode_q == MODE_REVERSE) ? addr_q + rd_len : addr_q + ADDR_W'(1);
                  addr_d  = first_d;
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            stop_d = stop_any;
            if (bus.play_sdram_finished) begin
               stop_d = 1'b0;
               if (stop_any) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
                  pos_d   = '0;
               end else begin
                  data_d  = bus.play_readdata;
                  cnt_d   = '0;
                  state_d = StPlay;
               end
            end
         end
         StPlay, StPause: begin
            if (play_stop) begin
               state_d = StIdle;
               done_d  = 1'b1;
               pos_d   = '0;
            end else if (play_pause) begin
               state_d = StPause;
            end else begin
               state_d = StPlay;
               if (hs) begin
                  if (cnt_q == per_word - CNT_W'(1)) begin
                     cnt_d = '0;
                     // End of clip is decided by offset alone; addresses may wrap.
                     if (pos_n >= len_q) begin
                        if (loop_q) begin
                           pos_d   = '0;
                           addr_d  = first_q;
                           state_d = StRead;
                        end else begin
                           pos_d   = '0;
                           done_d  = 1'b1;
                           state_d = StIdle;
                        end
                     end else begin
                        pos_d   = pos_n;
                        addr_d  = addr_n;
                        state_d = StRead;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule
